learn_sweep_ctrl: RTL
=====================

# learn_sweep_ctrl

- Drives the learn-mode side of the sine generator: raises `learn_en`, pulses `next_freq` once per step, and deasserts `learn_en` at the end so the generator restores its pre-learn frequency.
- At each step it waits for the output to settle, then measures the returned ADC signal's peak-to-peak amplitude over a fixed window.
- Each amplitude is written to an external table, and the block reports the step with the largest response.
- It sits between the key/UI logic and the generator, entirely in the clk_50m domain.

## Interface
Parameters:
- N_STEPS, 16: number of measured frequencies, including the start frequency.
- SETTLE_CYC, 50000: clk_50m cycles to wait after each frequency change before measuring.
- MEAS_CYC, 500000: length of the measurement window in clk_50m cycles.
- PULSE_CYC, 4: high time of the `next_freq` pulse, and the low gap after `learn_en` falls.
- ADC_W, 10: ADC sample width, signed.

Ports (reset rst_n, asynchronous, active-low; clock clk_50m):
- clk_50m  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle sweep request
- abort  in  1  one-cycle request to end the sweep early
- adc_data  in  ADC_W  signed ADC sample
- adc_valid  in  1  `adc_data` qualifier
- freq_in  in  16  generator frequency, in units of 100 Hz
- learn_en  out  1  level to the generator; high during the sweep
- next_freq  out  1  step pulse to the generator
- busy  out  1  high from accepted `start` until `done`
- done  out  1  one-cycle completion pulse
- amp_wr_en  out  1  table write strobe
- amp_wr_addr  out  8  step index
- amp_wr_data  out  ADC_W+1  unsigned peak-to-peak amplitude
- peak_idx  out  8  step index of the maximum amplitude
- peak_amp  out  ADC_W+1  maximum amplitude
- err  out  1  sticky frequency-mismatch flag

## Operation
- Reset values: all outputs 0; state IDLE.
- IDLE:
  - `start` → ARM: `learn_en`=1, `busy`=1, step counter k=0, `peak_amp`=0, `peak_idx`=0, `err`=0.
  - `start` is ignored while `busy`=1.
- ARM / SETTLE: count SETTLE_CYC cycles, then → MEAS.
- MEAS:
  - On entry, max is set to the most negative value and min to the most positive value.
  - On each `adc_valid`, max and min are updated.
  - After MEAS_CYC cycles → STORE.
- STORE (1 cycle):
  - amp = max−min, zero-extended to ADC_W+1; amp = 0 if no valid sample arrived in the window.
  - One-cycle write: `amp_wr_en`=1, `amp_wr_addr`=k, `amp_wr_data`=amp.
  - If amp > `peak_amp` (strict), update `peak_amp` and set `peak_idx`=k. On ties the lowest index wins.
  - If k == N_STEPS−1 → FINISH; otherwise k++ → STEP.
- STEP: `next_freq`=1 for PULSE_CYC cycles, then low → SETTLE.
- FINISH:
  - `learn_en`=0.
  - Hold for PULSE_CYC cycles so the generator registers the falling edge.
  - Then `done`=1 for one cycle, `busy`=0 → IDLE.
- `abort` in any state other than IDLE/FINISH:
  - → FINISH immediately; `next_freq` is forced to 0.
  - No write for the partial window.
  - `peak_*` keep their values so far.
- Expected generator frequency at step k = 10 + 2k (1 kHz start, 200 Hz per step).
- Reset mid-sweep: all outputs return to 0 asynchronously. The falling `learn_en` returns the generator to normal mode.

## Timing
- `learn_en` rises 1 cycle after `start` is sampled.
- Step 0 write occurs SETTLE_CYC + MEAS_CYC + 1 cycles after `learn_en` rises.
- Step period: PULSE_CYC + SETTLE_CYC + MEAS_CYC + 1 cycles.
- `done` occurs PULSE_CYC + 1 cycles after the last STORE.
- `peak_*` are valid from the cycle after each STORE.
- `peak_*` are final when `done` is asserted and hold until the next accepted `start`.
- Counters sized with $clog2 of their parameter; no wrap within a sweep.

## Configuration
- LEARN_FREQ_CHECK_EN defined:
  - On the last MEAS cycle, `freq_in` is compared with 10+2k.
  - On mismatch, `err` is set and stays set until the next accepted `start`.
- Undefined: `freq_in` is unused and `err` is tied to 0.

## Structure
- Package `learn_pkg` holds:
  - the state encoding (IDLE, ARM, SETTLE, MEAS, STORE, STEP, FINISH);
  - LEARN_FREQ_START=10 and LEARN_FREQ_STEP=2, shared with the generator side.
- Sub-module `amp_window`: signed min/max tracker with clear, sample-enable, and amp output.

## Test plan
Bench parameters: SETTLE_CYC=8, MEAS_CYC=16, PULSE_CYC=4, N_STEPS=4.
- Square wave ±100 at every step, `start` → 4 writes with data 200 at addr 0..3; `peak_idx`=0; `done` once; `learn_en` low before `done`.
- Amplitudes 50/300/300/120 → `peak_idx`=1, `peak_amp`=300.
- `abort` during step 2 MEAS → no write to addr 2; `learn_en` falls within 1 cycle; `done` follows after 5 cycles; `peak_*` reflect steps 0–1.
- `adc_valid` held at 0 for a whole sweep → all four writes carry data 0.
- With LEARN_FREQ_CHECK_EN, `freq_in` stuck at 10 → `err`=1 from step 1 onward; a new `start` clears it.
- Second `start` while `busy` → ignored; `rst_n` pulsed mid-STEP → all outputs 0; a fresh `start` then runs a full sweep.

Source files
------------

// File: rtl/learn_pkg.sv
// learn_pkg: state encoding and frequency constants shared by the learn sweep and the generator.
// Rev 1.0
`default_nettype none

package learn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    SETTLE = 3'd2,
    MEAS   = 3'd3,
    STORE  = 3'd4,
    STEP   = 3'd5,
    FINISH = 3'd6
  } learn_state_t;

  localparam logic [15:0] LEARN_FREQ_START = 16'd10;
  localparam logic [15:0] LEARN_FREQ_STEP  = 16'd2;

  // Generator frequency (100 Hz units) expected while measuring step k.
  function automatic logic [15:0] expected_freq(input logic [7:0] k);
    return LEARN_FREQ_START + LEARN_FREQ_STEP * {8'd0, k};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/learn_sweep_ctrl_amp_window.sv
// amp_window: signed min/max tracker; amp is max-min, or 0 if no sample since the last clear.
// Rev 1.0
`default_nettype none

module amp_window #(
  parameter int ADC_W = 10
) (
  input  logic                    clk_50m,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    sample_en,
  input  logic signed [ADC_W-1:0] sample,
  output logic        [ADC_W:0]   amp
);

  localparam logic signed [ADC_W-1:0] MOST_NEG = {1'b1, {(ADC_W-1){1'b0}}};
  localparam logic signed [ADC_W-1:0] MOST_POS = {1'b0, {(ADC_W-1){1'b1}}};

  logic signed [ADC_W-1:0] max_val;
  logic signed [ADC_W-1:0] min_val;
  logic                    seen;
  logic signed [ADC_W:0]   diff;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= MOST_NEG;
      min_val <= MOST_POS;
      seen    <= 1'b0;
    end else if (clr) begin
      max_val <= MOST_NEG;
      min_val <= MOST_POS;
      seen    <= 1'b0;
    end else if (sample_en) begin
      if (sample > max_val) max_val <= sample;
      if (sample < min_val) min_val <= sample;
      seen <= 1'b1;
    end
  end

  // One extra bit keeps the full-scale span (MOST_POS - MOST_NEG) unsigned-representable.
  assign diff = {max_val[ADC_W-1], max_val} - {min_val[ADC_W-1], min_val};
  assign amp  = seen ? $unsigned(diff) : '0;

endmodule

`default_nettype wire

// File: rtl/learn_sweep_ctrl.sv
// learn_sweep_ctrl: steps the generator through N_STEPS frequencies and records peak-to-peak response.
// Rev 1.0 -- optional frequency cross-check enabled by LEARN_FREQ_CHECK_EN.
`default_nettype none

module learn_sweep_ctrl
  import learn_pkg::*;
#(
  parameter int N_STEPS    = 16,
  parameter int SETTLE_CYC = 50000,
  parameter int MEAS_CYC   = 500000,
  parameter int PULSE_CYC  = 4,
  parameter int ADC_W      = 10
) (
  input  logic                    clk_50m,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [ADC_W-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic        [15:0]      freq_in,
  output logic                    learn_en,
  output logic                    next_freq,
  output logic                    busy,
  output logic                    done,
  output logic                    amp_wr_en,
  output logic        [7:0]       amp_wr_addr,
  output logic        [ADC_W:0]   amp_wr_data,
  output logic        [7:0]       peak_idx,
  output logic        [ADC_W:0]   peak_amp,
  output logic                    err
);

  localparam int CNT_MAX = max3(SETTLE_CYC, MEAS_CYC, PULSE_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int K_W     = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [K_W-1:0]   K_LAST      = K_W'(N_STEPS - 1);

  learn_state_t   state;
  learn_state_t   state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [K_W-1:0]   k;
  logic [K_W-1:0]   k_nxt;

  logic           abort_hit;
  logic           store_fire;
  logic           sweep_start;
  logic           meas_clr;
  logic           meas_sample;
  logic [ADC_W:0] amp;

  assign abort_hit   = abort && (state != IDLE) && (state != FINISH);
  assign store_fire  = (state == STORE) && !abort_hit;
  assign sweep_start = (state == IDLE) && start;
  assign meas_clr    = (state_nxt == MEAS) && (state != MEAS);
  assign meas_sample = (state == MEAS) && adc_valid;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    k_nxt     = k;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ARM;
          cnt_nxt   = '0;
          k_nxt     = '0;
        end
      end
      ARM, SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = MEAS;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      MEAS: begin
        if (cnt == MEAS_LAST) begin
          state_nxt = STORE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STORE: begin
        if (k == K_LAST) begin
          state_nxt = FINISH;
        end else begin
          state_nxt = STEP;
          k_nxt     = k + K_W'(1);
        end
      end
      STEP: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      FINISH: begin
        if (cnt == PULSE_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (abort_hit) begin
      state_nxt = FINISH;
      cnt_nxt   = '0;
      k_nxt     = k;
    end
  end

  amp_window #(
    .ADC_W(ADC_W)
  ) u_amp_window (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .clr      (meas_clr),
    .sample_en(meas_sample),
    .sample   (adc_data),
    .amp      (amp)
  );

  // Outputs are registered from the next state so they stay glitch-free toward the generator.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      learn_en    <= 1'b0;
      next_freq   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      amp_wr_en   <= 1'b0;
      amp_wr_addr <= '0;
      amp_wr_data <= '0;
      peak_idx    <= '0;
      peak_amp    <= '0;
    end else begin
      learn_en  <= (state_nxt != IDLE) && (state_nxt != FINISH);
      next_freq <= (state_nxt == STEP);
      busy      <= (state_nxt != IDLE);
      done      <= (state == FINISH) && (state_nxt == IDLE);
      amp_wr_en <= store_fire;
      if (sweep_start) begin
        peak_idx <= '0;
        peak_amp <= '0;
      end
      if (store_fire) begin
        amp_wr_addr <= 8'(k);
        amp_wr_data <= amp;
        if (amp > peak_amp) begin
          peak_amp <= amp;
          peak_idx <= 8'(k);
        end
      end
    end
  end

`ifdef LEARN_FREQ_CHECK_EN
  logic freq_bad;

  assign freq_bad = (state == MEAS) && (cnt == MEAS_LAST) &&
                    (freq_in != expected_freq(8'(k)));

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (sweep_start) begin
      err <= 1'b0;
    end else if (freq_bad) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_freq_in;

  assign unused_freq_in = ^freq_in;
  assign err            = 1'b0;
`endif

endmodule

`default_nettype wire
